// File: rtl/difftest_commit_monitor.sv
// difftest_commit_monitor
// Watches the per-cycle commit strobes of a core under co-simulation and
// decides whether the run ended in a trap (good or bad) or stalled with no
// commits for TIMEOUT enabled cycles. Counters and trap fields are held once
// the monitor leaves RUN, until reset.
//
// Optional feature macro: DIFFTEST_SIM_FINISH_EN
//   When defined, the monitor prints a one-line verdict and ends simulation
//   on the edge that enters TRAP or TIMEOUT. When undefined, the verdict is
//   visible only on the output ports.

module difftest_commit_monitor #(
    parameter int NUM_COMMIT = 6,
    parameter int TIMEOUT    = 5000,
    parameter int GOOD_CODE  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_COMMIT-1:0] io_commitValid,
    input  logic                  io_hasTrap,
    input  logic [2:0]            io_code,
    input  logic [63:0]           io_pc,
    input  logic [7:0]            io_coreid,
    output logic [63:0]           io_cycleCnt,
    output logic [63:0]           io_instrCnt,
    output logic [1:0]            io_state,
    output logic                  io_goodTrap,
    output logic [63:0]           io_trapPC,
    output logic [2:0]            io_trapCode
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_TRAP    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam int CNT_W  = $clog2(NUM_COMMIT + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0]        GOOD_CODE_L = 3'(GOOD_CODE);
    localparam logic [IDLE_W-1:0] IDLE_MAX    = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(TIMEOUT - 1);

    logic [1:0]        state_reg, state_next;
    logic [63:0]       cycle_cnt_reg, cycle_cnt_next;
    logic [63:0]       instr_cnt_reg, instr_cnt_next;
    logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic [63:0]       trap_pc_reg, trap_pc_next;
    logic [2:0]        trap_code_reg, trap_code_next;
    logic              good_trap_reg, good_trap_next;

    logic [CNT_W-1:0]  commit_count;
    logic              any_commit;
    logic              run_active;

    // Ripple popcount of the commit strobes; each stage adds one channel.
    generate
        for (genvar gi = 0; gi < NUM_COMMIT; gi++) begin : g_pop
            logic [CNT_W-1:0] sum;
            if (gi == 0) begin : g_first
                assign sum = CNT_W'(io_commitValid[gi]);
            end else begin : g_rest
                assign sum = g_pop[gi-1].sum + CNT_W'(io_commitValid[gi]);
            end
        end
    endgenerate

    assign commit_count = g_pop[NUM_COMMIT-1].sum;
    assign any_commit   = |io_commitValid;
    assign run_active   = (state_reg == ST_RUN) && enable;

    // Next-state: only an enabled RUN cycle changes anything; trap beats timeout.
    always_comb begin
        state_next     = state_reg;
        cycle_cnt_next = cycle_cnt_reg;
        instr_cnt_next = instr_cnt_reg;
        idle_cnt_next  = idle_cnt_reg;
        trap_pc_next   = trap_pc_reg;
        trap_code_next = trap_code_reg;
        good_trap_next = good_trap_reg;
        if (run_active) begin
            cycle_cnt_next = cycle_cnt_reg + 64'd1;
            instr_cnt_next = instr_cnt_reg + 64'(commit_count);
            if (any_commit) begin
                idle_cnt_next = '0;
            end else if (idle_cnt_reg != IDLE_MAX) begin
                idle_cnt_next = idle_cnt_reg + 1'b1;
            end
            if (io_hasTrap) begin
                state_next     = ST_TRAP;
                trap_pc_next   = io_pc;
                trap_code_next = io_code;
                good_trap_next = (io_code == GOOD_CODE_L);
            end else if (!any_commit && (idle_cnt_reg == IDLE_LAST)) begin
                state_next = ST_TIMEOUT;
            end
        end
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
            idle_cnt_reg  <= '0;
            trap_pc_reg   <= '0;
            trap_code_reg <= '0;
            good_trap_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cycle_cnt_reg <= cycle_cnt_next;
            instr_cnt_reg <= instr_cnt_next;
            idle_cnt_reg  <= idle_cnt_next;
            trap_pc_reg   <= trap_pc_next;
            trap_code_reg <= trap_code_next;
            good_trap_reg <= good_trap_next;
        end
    end

`ifdef DIFFTEST_SIM_FINISH_EN
    // Report the verdict and end the simulation on the edge leaving RUN.
    always_ff @(posedge clock) begin
        if (!reset && (state_reg == ST_RUN) && (state_next == ST_TRAP)) begin
            if (io_code == GOOD_CODE_L) begin
                $display("Core %0d: Hit Good Trap at pc %h", io_coreid, io_pc);
            end else begin
                $display("Core %0d: Hit Bad Trap code %0d at pc %h", io_coreid, io_code, io_pc);
            end
            $finish;
        end else if (!reset && (state_reg == ST_RUN) && (state_next == ST_TIMEOUT)) begin
            $display("Core %0d: No commit for %0d cycles, cycleCnt %0d", io_coreid, TIMEOUT, cycle_cnt_next);
            $finish;
        end
    end
`else
    // The core id only feeds the verdict messages.
    logic unused_coreid;
    assign unused_coreid = ^io_coreid;
`endif

    assign io_cycleCnt = cycle_cnt_reg;
    assign io_instrCnt = instr_cnt_reg;
    assign io_state    = state_reg;
    assign io_goodTrap = good_trap_reg;
    assign io_trapPC   = trap_pc_reg;
    assign io_trapCode = trap_code_reg;

endmodule

// File: tb/tb_difftest_commit_monitor.sv
// Directed bench for difftest_commit_monitor (NUM_COMMIT=6, TIMEOUT=8).
module tb_difftest_commit_monitor;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [5:0]  io_commitValid;
    logic        io_hasTrap;
    logic [2:0]  io_code;
    logic [63:0] io_pc;
    logic [7:0]  io_coreid;
    logic [63:0] io_cycleCnt;
    logic [63:0] io_instrCnt;
    logic [1:0]  io_state;
    logic        io_goodTrap;
    logic [63:0] io_trapPC;
    logic [2:0]  io_trapCode;

    int errors = 0;
    int checks = 0;

    difftest_commit_monitor #(
        .NUM_COMMIT(6),
        .TIMEOUT   (8),
        .GOOD_CODE (0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .io_commitValid(io_commitValid),
        .io_hasTrap    (io_hasTrap),
        .io_code       (io_code),
        .io_pc         (io_pc),
        .io_coreid     (io_coreid),
        .io_cycleCnt   (io_cycleCnt),
        .io_instrCnt   (io_instrCnt),
        .io_state      (io_state),
        .io_goodTrap   (io_goodTrap),
        .io_trapPC     (io_trapPC),
        .io_trapCode   (io_trapCode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        int          reps;
        logic        rst;
        logic        en;
        logic [5:0]  commit;
        logic        trap;
        logic [2:0]  code;
        logic [63:0] pc;
        logic [1:0]  e_state;
        logic [63:0] e_cycle;
        logic [63:0] e_instr;
        logic        e_good;
        logic [63:0] e_pc;
        logic [2:0]  e_code;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs and sample just after the rising edge.
    task automatic step(input logic rst, input logic en, input logic [5:0] cv,
                        input logic tr, input logic [2:0] cd, input logic [63:0] pc);
        reset          = rst;
        enable         = en;
        io_commitValid = cv;
        io_hasTrap     = tr;
        io_code        = cd;
        io_pc          = pc;
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string n, input vec_t v);
        check({n, ".state"}, 64'(io_state),    64'(v.e_state));
        check({n, ".cycle"}, io_cycleCnt,      v.e_cycle);
        check({n, ".instr"}, io_instrCnt,      v.e_instr);
        check({n, ".good"},  64'(io_goodTrap), 64'(v.e_good));
        check({n, ".pc"},    io_trapPC,        v.e_pc);
        check({n, ".code"},  64'(io_trapCode), 64'(v.e_code));
    endtask

    initial begin
        io_coreid = 8'd3;
        //          name          reps rst en commit   trap code pc              st cyc    ins   good e_pc            e_code
        vt[0]  = '{"reset",        2, 1, 1, 6'h3F, 1, 3'd5, 64'h55,         0, 64'd0,  64'd0,  0, 64'h0,          3'd0};
        vt[1]  = '{"commit3x10",  10, 0, 1, 6'h07, 0, 3'd0, 64'h0,          0, 64'd10, 64'd30, 0, 64'h0,          3'd0};
        vt[2]  = '{"disabled20",  20, 0, 0, 6'h3F, 1, 3'd3, 64'h77,         0, 64'd10, 64'd30, 0, 64'h0,          3'd0};
        vt[3]  = '{"goodtrap",     1, 0, 1, 6'h21, 1, 3'd0, 64'h80001234,   1, 64'd11, 64'd32, 1, 64'h80001234,   3'd0};
        vt[4]  = '{"trapfrozen",   5, 0, 1, 6'h3F, 1, 3'd5, 64'h9999,       1, 64'd11, 64'd32, 1, 64'h80001234,   3'd0};
        vt[5]  = '{"rst_in_trap",  1, 1, 1, 6'h3F, 1, 3'd2, 64'h4444,       0, 64'd0,  64'd0,  0, 64'h0,          3'd0};
        vt[6]  = '{"idle7",        7, 0, 1, 6'h00, 0, 3'd0, 64'h0,          0, 64'd7,  64'd0,  0, 64'h0,          3'd0};
        vt[7]  = '{"timeout",      1, 0, 1, 6'h00, 0, 3'd0, 64'h0,          2, 64'd8,  64'd0,  0, 64'h0,          3'd0};
        vt[8]  = '{"tofrozen",     3, 0, 1, 6'h3F, 1, 3'd1, 64'h1,          2, 64'd8,  64'd0,  0, 64'h0,          3'd0};
        vt[9]  = '{"rst_in_to",    1, 1, 0, 6'h00, 0, 3'd0, 64'h0,          0, 64'd0,  64'd0,  0, 64'h0,          3'd0};
        vt[10] = '{"idle6",        6, 0, 1, 6'h00, 0, 3'd0, 64'h0,          0, 64'd6,  64'd0,  0, 64'h0,          3'd0};
        vt[11] = '{"commit7th",    1, 0, 1, 6'h10, 0, 3'd0, 64'h0,          0, 64'd7,  64'd1,  0, 64'h0,          3'd0};
        vt[12] = '{"idle7again",   7, 0, 1, 6'h00, 0, 3'd0, 64'h0,          0, 64'd14, 64'd1,  0, 64'h0,          3'd0};
        vt[13] = '{"timeout2",     1, 0, 1, 6'h00, 0, 3'd0, 64'h0,          2, 64'd15, 64'd1,  0, 64'h0,          3'd0};
        vt[14] = '{"rst3",         1, 1, 1, 6'h00, 0, 3'd0, 64'h0,          0, 64'd0,  64'd0,  0, 64'h0,          3'd0};
        vt[15] = '{"idle7b",       7, 0, 1, 6'h00, 0, 3'd0, 64'h0,          0, 64'd7,  64'd0,  0, 64'h0,          3'd0};
        vt[16] = '{"trap_vs_to",   1, 0, 1, 6'h00, 1, 3'd3, 64'h1000,       1, 64'd8,  64'd0,  0, 64'h1000,       3'd3};
        vt[17] = '{"rst4",         1, 1, 1, 6'h00, 0, 3'd0, 64'h0,          0, 64'd0,  64'd0,  0, 64'h0,          3'd0};
        vt[18] = '{"idle7c",       7, 0, 1, 6'h00, 0, 3'd0, 64'h0,          0, 64'd7,  64'd0,  0, 64'h0,          3'd0};
        vt[19] = '{"dis_idle",    20, 0, 0, 6'h00, 1, 3'd6, 64'hABC,        0, 64'd7,  64'd0,  0, 64'h0,          3'd0};

        for (int i = 0; i < NV; i++) begin
            for (int r = 0; r < vt[i].reps; r++) begin
                step(vt[i].rst, vt[i].en, vt[i].commit, vt[i].trap, vt[i].code, vt[i].pc);
            end
            check_all(vt[i].name, vt[i]);
            $display("vec %0d %s: state=%0d cycle=%0d instr=%0d good=%0d pc=%0h code=%0d",
                     i, vt[i].name, io_state, io_cycleCnt, io_instrCnt, io_goodTrap, io_trapPC, io_trapCode);
        end

        // After the disabled stretch, the idle count is still 7: one more
        // enabled idle cycle must time out immediately.
        step(0, 1, 6'h00, 0, 3'd0, 64'h0);
        check("dis_idle_then_to.state", 64'(io_state), 64'd2);
        check("dis_idle_then_to.cycle", io_cycleCnt, 64'd8);
        $display("seq dis_idle_then_to: state=%0d cycle=%0d", io_state, io_cycleCnt);

        // Walk to the timeout one cycle at a time, RUN on each of the first 7.
        step(1, 1, 6'h00, 0, 3'd0, 64'h0);
        for (int c = 1; c <= 8; c++) begin
            step(0, 1, 6'h00, 0, 3'd0, 64'h0);
            check($sformatf("walk%0d.state", c), 64'(io_state), (c == 8) ? 64'd2 : 64'd0);
            check($sformatf("walk%0d.cycle", c), io_cycleCnt, 64'(c));
            $display("seq walk cycle %0d: state=%0d cycle=%0d", c, io_state, io_cycleCnt);
        end

        // Bad trap with full-width commit on the trap cycle itself.
        step(1, 1, 6'h00, 0, 3'd0, 64'h0);
        step(0, 1, 6'h3F, 0, 3'd0, 64'h0);
        step(0, 1, 6'h2A, 1, 3'd7, 64'hFFFF_0000_DEAD_BEEF);
        check("badtrap.state", 64'(io_state), 64'd1);
        check("badtrap.instr", io_instrCnt, 64'd9);
        check("badtrap.cycle", io_cycleCnt, 64'd2);
        check("badtrap.good",  64'(io_goodTrap), 64'd0);
        check("badtrap.code",  64'(io_trapCode), 64'd7);
        check("badtrap.pc",    io_trapPC, 64'hFFFF_0000_DEAD_BEEF);
        $display("seq badtrap: state=%0d instr=%0d code=%0d pc=%0h", io_state, io_instrCnt, io_trapCode, io_trapPC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/difftest_commit_monitor.md
DIFFTEST_COMMIT_MONITOR -- requirements
Module: difftest_commit_monitor

Interface
REQ-001 SHALL have parameter NUM_COMMIT, default 6: number of parallel commit channels (1..16).
REQ-002 SHALL have parameter TIMEOUT, default 5000: enabled no-commit cycles before a timeout (1..2^20).
REQ-003 SHALL have parameter GOOD_CODE, default 0: trap code value reported as a good trap.
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  monitor enable; low freezes all internal state.
REQ-007 SHALL have port io_commitValid  in  NUM_COMMIT  per-channel instruction-commit strobe.
REQ-008 SHALL have port io_hasTrap  in  1  trap request for this cycle.
REQ-009 SHALL have port io_code  in  3  trap code sampled with io_hasTrap.
REQ-010 SHALL have port io_pc  in  64  trap PC sampled with io_hasTrap.
REQ-011 SHALL have port io_coreid  in  8  core identifier; used only in messages.
REQ-012 SHALL have port io_cycleCnt  out  64  enabled cycles spent in RUN.
REQ-013 SHALL have port io_instrCnt  out  64  total committed instructions.
REQ-014 SHALL have port io_state  out  2  0=RUN, 1=TRAP, 2=TIMEOUT; 3 unused.
REQ-015 SHALL have port io_goodTrap  out  1  high in TRAP when latched code equals GOOD_CODE.
REQ-016 SHALL have port io_trapPC  out  64  latched trap PC.
REQ-017 SHALL have port io_trapCode  out  3  latched trap code.

Function
REQ-018 SHALL implement FSM RUN -> TRAP, RUN -> TIMEOUT; TRAP and TIMEOUT terminal until reset.
REQ-019 SHALL, in RUN with enable=1, increment io_cycleCnt by 1 per cycle, wrapping modulo 2^64.
REQ-020 SHALL, in RUN with enable=1, add popcount(io_commitValid) to io_instrCnt per cycle, zero-extended, modulo 2^64.
REQ-021 SHALL keep an idle counter: cleared on any enabled RUN cycle with a commit, else incremented, saturating at TIMEOUT.
REQ-022 SHALL move RUN -> TIMEOUT on the edge ending the enabled cycle where the idle count before increment equals TIMEOUT-1 and no commit occurs.
REQ-023 SHALL move RUN -> TRAP on the edge ending an enabled cycle with io_hasTrap=1, latching io_code and io_pc.
REQ-024 SHALL give trap priority when trap and timeout conditions coincide; state becomes TRAP.
REQ-025 SHALL count commits and the cycle of the trap or timeout cycle itself before freezing.
REQ-026 SHALL freeze all counters and latched fields in TRAP and TIMEOUT; further io_hasTrap ignored.
REQ-027 SHALL hold all state, including the idle counter, when enable=0; io_hasTrap ignored while enable=0.
REQ-028 SHALL drive io_goodTrap low outside TRAP; all outputs registered, zero combinational input-to-output paths.

Reset
REQ-029 SHALL, with reset=1 at a rising edge, set state RUN and all counters, io_trapPC, io_trapCode, io_goodTrap to 0.
REQ-030 SHALL let reset override enable and every other input in the same cycle, including mid-trap or post-timeout.

Configuration
REQ-031 SHALL recognise macro DIFFTEST_SIM_FINISH_EN.
REQ-032 SHALL, with DIFFTEST_SIM_FINISH_EN defined, on entering TRAP print "Core <coreid>: Hit Good Trap at pc <hex>" or "Core <coreid>: Hit Bad Trap code <n> at pc <hex>", then call $finish on the same edge.
REQ-033 SHALL, with DIFFTEST_SIM_FINISH_EN defined, on entering TIMEOUT print "Core <coreid>: No commit for <TIMEOUT> cycles" with io_cycleCnt, then call $finish.
REQ-034 SHALL, with DIFFTEST_SIM_FINISH_EN undefined, contain no system tasks; behaviour visible only on outputs.

Verification
REQ-035 SHALL cover: NUM_COMMIT=6, 10 enabled cycles with io_commitValid=6'b000111 -> io_instrCnt=30, io_cycleCnt=10, io_state=0.
REQ-036 SHALL cover: io_hasTrap=1, io_code=0, io_pc=0x80001234 -> next cycle io_state=1, io_goodTrap=1, io_trapPC=0x80001234; counters frozen after.
REQ-037 SHALL cover: TIMEOUT=8, no commits for 8 enabled cycles -> io_state=2 after 8th edge; commit on 7th cycle instead -> stays RUN, idle count restarts.
REQ-038 SHALL cover: trap (io_code=3) in the same cycle as the timeout condition -> io_state=1, io_goodTrap=0, io_trapCode=3.
REQ-039 SHALL cover: enable=0 for 20 cycles with commits and io_hasTrap=1 -> all outputs unchanged, no timeout.
REQ-040 SHALL cover: reset asserted one cycle while in TRAP -> next cycle io_state=0, io_cycleCnt=0, io_instrCnt=0, io_trapPC=0.
